song_player: RTL and testbench
==============================

# song_player

Sequencer that plays a stored melody by walking the song ROM address by address. It latches the selected song on `start` and presents each entry's note to the downstream tone generator for the entry's duration, with a short silent gap between notes. It stops at the ROM's end marker (duration 0) or after address 31. It sits between the user-control logic and the song ROM / tone generator pair, and is the only block that drives the ROM address.

## Interface
Parameters:
- `TICK_DIV`, 10000: clock cycles per duration unit (0.1 ms at 100 MHz); must be ≥ 2.
- `GAP_UNITS`, 200: silent articulation units at the end of each note; 0 disables the gap.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: one-cycle pulse; begins playback from address 0; ignored unless IDLE.
- `stop`  in  1: one-cycle pulse; aborts playback; has priority over all other inputs.
- `pause`  in  1: level; freezes all timing while high.
- `song_sel`  in  4: song index, sampled only on an accepted `start`.
- `rom_song`  out  4: latched song index to the ROM.
- `rom_address`  out  5: registered ROM address.
- `rom_note`  in  4: note from the ROM (0 = rest, 1–7 = scale degree); combinational from the address.
- `rom_duration`  in  16: duration in units; 0 = end of song.
- `note`  out  4: registered current note to the tone generator.
- `note_on`  out  1: tone-generator enable.
- `playing`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at natural song end (not on `stop`).

## Operation
- States: IDLE, FETCH, PLAY, GAP, DONE.
- IDLE, on `start`:
  - `rom_song` takes `song_sel` and `rom_address` takes 0.
  - Next state is FETCH.
- FETCH (exactly 1 cycle): register `rom_note` and `rom_duration`; clear the prescaler.
  - If duration is 0, go to DONE.
  - If duration > `GAP_UNITS`: play units P = duration − `GAP_UNITS`, gap units G = `GAP_UNITS`.
  - Otherwise P = duration and G = 0.
  - Go to PLAY.
- PLAY:
  - `note` = latched note.
  - `note_on` = 1 if note ≠ 0.
  - Decrement the unit counter on each tick.
  - When P units have elapsed: go to GAP if G > 0, else advance.
- GAP: `note_on` = 0, `note` holds its value; count G units, then advance.
- Advance:
  - If `rom_address` = 31, go to DONE.
  - Otherwise increment the address and go to FETCH.
- DONE (1 cycle): `done` = 1, `note` = 0, `note_on` = 0; then go to IDLE. `rom_address` and `rom_song` hold their values.
- `stop` in any state: on the next edge go to IDLE with `note` = 0 and `note_on` = 0. No `done` pulse.
- `pause` high:
  - Prescaler and unit counter hold; state does not advance.
  - `note_on` is forced to 0.
  - Releasing `pause` resumes the remaining count exactly.
  - FETCH and DONE complete even when `pause` is high.
- `start` while not IDLE: ignored. `song_sel` changes mid-song have no effect.
- Unit counter: 16 bits. Prescaler: width = clog2(`TICK_DIV`); it emits a tick when it reaches `TICK_DIV`−1, then wraps to 0.

## Timing
- Reset values:
  - state IDLE.
  - `rom_address`, `rom_song`, `note`: 0.
  - `note_on`, `playing`, `done`: 0.
  - Prescaler and counters: 0.
- `start` at edge k: FETCH at k+1 and PLAY at k+2, with `note_on` asserted from k+2.
- Per ROM entry (no pause): 1 FETCH cycle + duration × `TICK_DIV` cycles.
- Each address increment is registered in the advance cycle, so the ROM outputs are stable for the whole following FETCH cycle.
- `done` asserts 1 cycle after the last advance or after a FETCH that sees a zero duration.
- Simultaneous inputs:
  - `stop` + `start` in IDLE: stays IDLE.
  - `stop` + `pause`: `stop` wins.
  - `start` + `pause` in IDLE: start is accepted and the sequence freezes in PLAY.

## Structure
- Shared package/header holds:
  - state encodings;
  - `LAST_ADDR` = 31;
  - `REST_NOTE` = 0;
  - note-code width 4 and duration width 16, shared with the ROM and tone generator.
- Sub-module `duration_tick`: parameterised prescaler with clear and enable inputs and a tick output.

## Test plan
All scenarios use `TICK_DIV`=4 and `GAP_UNITS`=2 with a behavioural ROM model.
- **Normal entry.** Reset, then `start` with `song_sel`=0, ROM entry 0 = note 1, duration 5.
  - `note_on` high for 12 cycles, then low for 8.
  - `rom_address` becomes 1 on the advance; FETCH occupies 1 cycle.
- **Rest and short note.**
  - Entry with note 0, duration 3: `note_on` stays 0 for 4 cycles, then 8 gap cycles.
  - Entry with duration 2: 8 cycles of PLAY, no GAP.
- **End marker.** Duration 0 at address 28: no PLAY, `done` pulses once, `playing` falls the next cycle, `rom_address` stays 28.
- **Full ROM.** All 32 entries non-zero: exactly 32 FETCH states, `done` after address 31, no wrap to 0.
- **Pause.** `pause` held for 10 cycles mid-PLAY: `note_on` is 0 during the pause, and total PLAY time extends by exactly 10 cycles.
- **Stop and restart.** `stop` mid-GAP: IDLE next cycle with `note`=0 and no `done`. A `start` in the following cycle restarts from address 0 with the newly sampled `song_sel`.

Source files
------------

// File: rtl/song_player_pkg.sv
// Shared constants for the song player, song ROM and tone generator.
// Holds the FSM encodings, the entry field widths and the play/gap split helper.
package song_player_pkg;

    localparam int NOTE_W = 4;
    localparam int DUR_W  = 16;
    localparam int ADDR_W = 5;
    localparam int SONG_W = 4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = 5'd31;
    localparam logic [NOTE_W-1:0] REST_NOTE = 4'd0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Sounding part of an entry; the articulation gap is only carved out of long notes.
    function automatic logic [DUR_W-1:0] play_units(input logic [DUR_W-1:0] dur,
                                                    input logic [DUR_W-1:0] gap);
        return (dur > gap) ? (dur - gap) : dur;
    endfunction

endpackage

// File: rtl/song_player_if.sv
// Control, ROM and tone-generator signals of the song player.
// The master modport is the player itself; slave is the surrounding logic.
interface song_player_if;
    import song_player_pkg::*;

    logic              start;
    logic              stop;
    logic              pause;
    logic [SONG_W-1:0] song_sel;
    logic [SONG_W-1:0] rom_song;
    logic [ADDR_W-1:0] rom_address;
    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_duration;
    logic [NOTE_W-1:0] note;
    logic              note_on;
    logic              playing;
    logic              done;

    modport master (
        input  start, stop, pause, song_sel, rom_note, rom_duration,
        output rom_song, rom_address, note, note_on, playing, done
    );

    modport slave (
        output start, stop, pause, song_sel, rom_note, rom_duration,
        input  rom_song, rom_address, note, note_on, playing, done
    );

endinterface

// File: rtl/song_player_duration_tick.sv
// Duration-unit prescaler: counts enabled cycles and pulses tick_o on the last
// cycle of each TICK_DIV-cycle unit. clr_i restarts the unit from zero.
module duration_tick #(
    parameter int TICK_DIV = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next prescaler value: clear wins, otherwise count and wrap while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : (cnt_q + W'(1));
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/song_player.sv
// Melody sequencer: walks the song ROM entry by entry, sounding each note for
// its duration with a trailing silent gap, until an end marker or address 31.
module song_player
    import song_player_pkg::*;
#(
    parameter int TICK_DIV  = 10000,
    parameter int GAP_UNITS = 200
) (
    input  logic          clk,
    input  logic          rst_n,
    song_player_if.master bus
);

    localparam logic [DUR_W-1:0] GAP_W = DUR_W'(GAP_UNITS);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  cnt_q, cnt_d;
    logic              gap_q, gap_d;
    logic              note_on_q, note_on_d;
    logic              playing_q, playing_d;
    logic              done_q, done_d;
    logic              tick_s;
    logic              adv_s;

    duration_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == ST_FETCH),
        .en_i   (((state_q == ST_PLAY) || (state_q == ST_GAP)) && !bus.pause),
        .tick_o (tick_s)
    );

    // Sequencing: next state, unit counter, address and registered outputs.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        song_d  = song_q;
        note_d  = note_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        adv_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    song_d  = bus.song_sel;
                    addr_d  = '0;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                note_d = bus.rom_note;
                if (bus.rom_duration == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = play_units(bus.rom_duration, GAP_W);
                    gap_d   = (GAP_W != '0) && (bus.rom_duration > GAP_W);
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY, ST_GAP: begin
                // Pause gates the tick, so the count and state simply hold.
                if (tick_s) begin
                    if (cnt_q != 16'd1) begin
                        cnt_d = cnt_q - 16'd1;
                    end else if ((state_q == ST_PLAY) && gap_q) begin
                        cnt_d   = GAP_W;
                        state_d = ST_GAP;
                    end else begin
                        adv_s = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (adv_s) begin
            if (addr_q == LAST_ADDR) begin
                state_d = ST_DONE;
            end else begin
                addr_d  = addr_q + 5'd1;
                state_d = ST_FETCH;
            end
        end else begin
            addr_d = addr_d;
        end

        if (bus.stop) begin
            state_d = ST_IDLE;
            addr_d  = addr_q;
        end else begin
            state_d = state_d;
        end

        if (bus.stop || (state_d == ST_DONE)) begin
            note_d = REST_NOTE;
        end else begin
            note_d = note_d;
        end

        note_on_d = (state_d == ST_PLAY) && (note_d != REST_NOTE) && !bus.pause;
        playing_d = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            song_q    <= '0;
            note_q    <= '0;
            cnt_q     <= '0;
            gap_q     <= 1'b0;
            note_on_q <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            song_q    <= song_d;
            note_q    <= note_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            note_on_q <= note_on_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    assign bus.rom_song    = song_q;
    assign bus.rom_address = addr_q;
    assign bus.note        = note_q;
    assign bus.note_on     = note_on_q;
    assign bus.playing     = playing_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_song_player.sv
// Scoreboard bench for song_player: a melody-level model expands each song into
// the expected per-cycle outputs; a monitor compares them against the DUT.
module tb_song_player;
    import song_player_pkg::*;

    localparam int TD = 4;
    localparam int GU = 2;
    localparam int PH_IDLE  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_GAP   = 3;
    localparam int PH_DONE  = 4;
    localparam int NO_STOP  = -2;
    localparam int ANY_STOP = -1;

    typedef struct packed {
        logic [3:0] song;
        logic [4:0] addr;
        logic [3:0] note;
        logic       note_on;
        logic       playing;
        logic       done;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    song_player_if sp_if ();

    song_player #(.TICK_DIV(TD), .GAP_UNITS(GU)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sp_if)
    );

    always #5 clk = ~clk;

    logic [3:0]  note_mem [16][32];
    logic [15:0] dur_mem  [16][32];

    assign sp_if.rom_note     = note_mem[sp_if.rom_song][sp_if.rom_address];
    assign sp_if.rom_duration = dur_mem[sp_if.rom_song][sp_if.rom_address];

    obs_t exp_q[$];
    obs_t tr[$];
    int   ph[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic [3:0] cur_song = 4'd0;
    logic [4:0] cur_addr = 5'd0;

    function automatic obs_t mk(input logic [3:0] s, input logic [4:0] a, input logic [3:0] n,
                                input logic on, input logic pl, input logic dn);
        return {s, a, n, on, pl, dn};
    endfunction

    // Expand a song into its cycle trace: entry 0 is the idle cycle before start.
    task automatic build(input int sg);
        logic [3:0] prev_n;
        logic [3:0] n;
        int d, p, g, last_a;
        tr.delete();
        ph.delete();
        tr.push_back(mk(cur_song, cur_addr, 4'd0, 1'b0, 1'b0, 1'b0));
        ph.push_back(PH_IDLE);
        prev_n = 4'd0;
        last_a = 0;
        for (int a = 0; a < 32; a++) begin
            last_a = a;
            d = int'(dur_mem[sg][a]);
            n = note_mem[sg][a];
            tr.push_back(mk(4'(sg), 5'(a), prev_n, 1'b0, 1'b1, 1'b0));
            ph.push_back(PH_FETCH);
            if (d == 0) break;
            p = (d > GU) ? d - GU : d;
            g = (d > GU) ? GU : 0;
            for (int c = 0; c < p * TD; c++) begin
                tr.push_back(mk(4'(sg), 5'(a), n, n != 4'd0, 1'b1, 1'b0));
                ph.push_back(PH_PLAY);
            end
            for (int c = 0; c < g * TD; c++) begin
                tr.push_back(mk(4'(sg), 5'(a), n, 1'b0, 1'b1, 1'b0));
                ph.push_back(PH_GAP);
            end
            prev_n = n;
        end
        tr.push_back(mk(4'(sg), 5'(last_a), 4'd0, 1'b0, 1'b1, 1'b1));
        ph.push_back(PH_DONE);
        tr.push_back(mk(4'(sg), 5'(last_a), 4'd0, 1'b0, 1'b0, 1'b0));
        ph.push_back(PH_IDLE);
    endtask

    // A pause of n cycles starting at a PLAY cycle repeats that cycle, silenced.
    task automatic add_pause(input int n, output int m);
        int cand[$];
        obs_t e;
        m = -1;
        foreach (ph[i]) if (ph[i] == PH_PLAY) cand.push_back(i);
        if (cand.size() == 0) return;
        m = cand[$urandom_range(0, cand.size() - 1)];
        e = tr[m];
        e.note_on = 1'b0;
        for (int i = 0; i < n; i++) begin
            tr.insert(m + 1, e);
            ph.insert(m + 1, PH_PLAY);
        end
    endtask

    // Stop sampled after trace cycle m: the trace ends; the next idle cycle follows.
    task automatic add_stop(input int want, output int m);
        int cand[$];
        m = -1;
        for (int i = 1; i < tr.size() - 1; i++)
            if ((want == ANY_STOP && ph[i] != PH_IDLE) || ph[i] == want) cand.push_back(i);
        if (cand.size() == 0) return;
        m = cand[$urandom_range(0, cand.size() - 1)];
        while (tr.size() > m + 1) begin
            void'(tr.pop_back());
            void'(ph.pop_back());
        end
    endtask

    task automatic drive(input int sg, input int pm, input int pn, input int sm);
        int len;
        len = tr.size();
        foreach (tr[i]) exp_q.push_back(tr[i]);
        cur_song = tr[len-1].song;
        cur_addr = tr[len-1].addr;
        for (int s = 0; s < len; s++) begin
            sp_if.start    = (s == 0) || (s >= 1 && s <= len - 2 && $urandom_range(0, 7) == 0);
            sp_if.song_sel = (s == 0) ? 4'(sg) : 4'($urandom_range(0, 15));
            sp_if.pause    = (pm >= 0) && (s >= pm) && (s < pm + pn);
            sp_if.stop     = (s == sm);
            @(posedge clk);
            #1;
        end
        sp_if.start = 1'b0;
        sp_if.stop  = 1'b0;
        sp_if.pause = 1'b0;
    endtask

    task automatic run_song(input int sg, input int pn, input int stop_ph);
        int pm, sm;
        build(sg);
        pm = -1;
        sm = -1;
        if (pn > 0) add_pause(pn, pm);
        if (stop_ph != NO_STOP) add_stop(stop_ph, sm);
        drive(sg, pm, pn, sm);
    endtask

    // start and stop together in IDLE: nothing may change.
    task automatic run_start_stop();
        tr.delete();
        ph.delete();
        repeat (2) begin
            tr.push_back(mk(cur_song, cur_addr, 4'd0, 1'b0, 1'b0, 1'b0));
            ph.push_back(PH_IDLE);
        end
        drive(int'(~cur_song), -1, 0, 0);
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {sp_if.rom_song, sp_if.rom_address, sp_if.note, sp_if.note_on,
                 sp_if.playing, sp_if.done};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_check #%0d: got song=%0d addr=%0d note=%0d on=%b playing=%b done=%b, expected song=%0d addr=%0d note=%0d on=%b playing=%b done=%b",
                         n_checks, a.song, a.addr, a.note, a.note_on, a.playing, a.done,
                         e.song, e.addr, e.note, e.note_on, e.playing, e.done);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 16; s++)
            for (int a = 0; a < 32; a++) begin
                note_mem[s][a] = 4'($urandom_range(0, 7));
                dur_mem[s][a]  = 16'($urandom_range(0, 4));
            end
        note_mem[0][0] = 4'd1; dur_mem[0][0] = 16'd5;
        note_mem[0][1] = 4'd0; dur_mem[0][1] = 16'd3;
        note_mem[0][2] = 4'd3; dur_mem[0][2] = 16'd2;
        dur_mem[0][3]  = 16'd0;
        for (int a = 0; a < 32; a++) begin
            dur_mem[1][a] = (a < 28) ? 16'($urandom_range(1, 2)) : 16'd0;
            dur_mem[2][a] = 16'($urandom_range(1, 3));
        end
        note_mem[3][0] = 4'd5; dur_mem[3][0] = 16'd5;
        dur_mem[4][0]  = 16'($urandom_range(1, 4));

        sp_if.start = 1'b0;
        sp_if.stop = 1'b0;
        sp_if.pause = 1'b0;
        sp_if.song_sel = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) exp_q.push_back(mk(4'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        #1;

        run_song(0, 0, NO_STOP);
        run_start_stop();
        run_song(1, 0, NO_STOP);
        run_song(2, 0, NO_STOP);
        run_song(3, 10, NO_STOP);
        run_song(0, 0, PH_GAP);
        run_song(4, 0, NO_STOP);
        for (int i = 0; i < 8; i++)
            run_song(5 + i, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : 0,
                     ($urandom_range(0, 1) == 1) ? ANY_STOP : NO_STOP);
        exp_q.push_back(mk(cur_song, cur_addr, 4'd0, 1'b0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
